ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 64x16 program/data RAM between three requesters: boot loader (index 0), debug/scan port (index 1) and CPU control unit (index 2).
- Replaces the static boot-mux in front of the RAM with a registered request/grant scheduler.
- Enforces exclusive boot-loader ownership while boot_lock is high.
- Prevents CPU starvation and returns synchronous read data with a per-requester valid strobe.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 16, RAM data width.
- STARVE_LIMIT, 8, consecutive lost arbitrations after which the CPU requester is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low, all state is frozen
- boot_lock  in  1  high = only requester 0 may be granted
- req  in  3  access request per requester; level, held until gnt
- we  in  3  per-requester write flag (1 = write)
- adr  in  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  packed write data, same packing as adr
- gnt  out  3  one-hot, one-cycle grant pulse
- rvalid  out  3  one-hot, one-cycle read-data-valid pulse
- rdata  out  DATA_W  read data, valid only while an rvalid bit is high
- ram_adr  out  ADDR_W  RAM address
- ram_in  out  DATA_W  RAM write data
- ram_rw  out  1  RAM write strobe (1 = write)
- ram_enable  out  1  RAM access enable
- ram_out  in  DATA_W  RAM synchronous read data

Behaviour:
- Reset (asynchronous, any time, including mid-access): state=IDLE; gnt, rvalid, ram_enable, ram_rw = 0; ram_adr, ram_in, rdata = 0; starvation counter = 0; pending access discarded.
- All transitions occur only on clk edges with ce=1. With ce=0 every register holds, including outputs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - eligible = req masked by boot_lock (only bit 0 remains when boot_lock=1).
  - If any bit is eligible, pick the winner, latch its we/adr/wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- Winner selection:
  - Fixed priority 0 > 1 > 2.
  - Override: if starvation counter == STARVE_LIMIT and req[2] is eligible, requester 2 wins.
- ACCESS (1 cycle):
  - ram_enable=1; ram_adr/ram_in come from the latched values; ram_rw = latched we.
  - gnt[winner]=1 for this cycle only.
  - Next state: write -> IDLE; read -> RESP.
- RESP (1 cycle):
  - ram_enable=0; rvalid[winner]=1; rdata = ram_out (combinational pass-through from the RAM's registered output).
  - Next state: IDLE.
- Latency and throughput:
  - Read: req seen in IDLE -> gnt 1 cycle later -> rvalid 2 cycles later. One read per 3 cycles.
  - Write: one write per 2 cycles.
- Requester obligations: hold req/we/adr/wdata stable until gnt. req still high in the cycle after gnt is treated as a new request.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each arbitration where req[2] is eligible and loses.
  - Clears when requester 2 wins, or when req[2] is low at arbitration.
- boot_lock changes mid-access do not abort the access; the new mask applies at the next IDLE arbitration.
- Simultaneous requests: exactly one gnt per ACCESS. Losers stay pending.
- With no eligible request the RAM is idle (ram_enable=0).

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds output acc_cnt (3*16 bits): per-requester 16-bit saturating counters of granted accesses.
  - Adds input stats_clr: synchronous clear, takes priority over increment in the same cycle.
  - Counters reset to 0 on rst_n.
- Undefined: no counters, no extra ports; core behaviour identical.

Decomposition:
- Package ram_arb_pkg:
  - State encoding IDLE/ACCESS/RESP.
  - Requester indices REQ_BOOT=0, REQ_DBG=1, REQ_CPU=2.
  - Constant NREQ=3.
  - RAM_WRITE=1 / RAM_READ=0 encodings.
- Sub-module ram_arb_prio: combinational masking, fixed-priority pick and starvation override; outputs one-hot winner and a valid flag.

Test Plan:
- Reset mid-ACCESS: assert rst_n=0 during the write of requester 1 -> all outputs 0 immediately, no gnt, FSM returns to IDLE.
- Single CPU read, adr=6'h05, RAM holds 16'hBEEF: gnt[2] at T+1, ram_enable=1/ram_rw=0 at T+1, rvalid[2]=1 with rdata=16'hBEEF at T+2.
- Simultaneous req=3'b111, all reads: grants occur in order 0, 1, 2 at 3-cycle spacing; exactly one gnt bit per pulse.
- boot_lock=1 with req=3'b110 held for 20 cycles -> no gnt and ram_enable stays 0. Raise req[0] (write 16'h1234 to adr 6'h3F) -> gnt[0] and ram_rw=1 at the next ACCESS.
- Starvation: requesters 0 and 2 request continuously, STARVE_LIMIT=8 -> gnt[2] after 8 consecutive gnt[0] pulses, then the counter is back at 0.
- ce=0 held 5 cycles during RESP -> rvalid and rdata held, no state change; completes normally when ce returns to 1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding,
// requester indices, requester count and RAM direction encodings.
package ram_arb_pkg;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned REQ_BOOT = 0;
  localparam int unsigned REQ_DBG  = 1;
  localparam int unsigned REQ_CPU  = 2;

  // Starvation counter width; holds STARVE_LIMIT values 1..15
  localparam int unsigned STARVE_W = 4;

  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side bus of the RAM port arbiter.
//   master : requesters + RAM model (drive req/we/adr/wdata/ram_out)
//   slave  : arbiter (drives gnt/rvalid/rdata and the RAM control signals)
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
);
  import ram_arb_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] adr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [ADDR_W-1:0]      ram_adr;
  logic [DATA_W-1:0]      ram_in;
  logic                   ram_rw;
  logic                   ram_enable;
  logic [DATA_W-1:0]      ram_out;

  modport master (
    output req, we, adr, wdata, ram_out,
    input  gnt, rvalid, rdata, ram_adr, ram_in, ram_rw, ram_enable
  );

  modport slave (
    input  req, we, adr, wdata, ram_out,
    output gnt, rvalid, rdata, ram_adr, ram_in, ram_rw, ram_enable
  );

endinterface

// File: rtl/ram_arb_prio.sv
// Combinational winner selection: boot_lock masking, fixed priority
// 0 > 1 > 2, and the CPU starvation override.
//   i_req          raw request vector
//   i_boot_lock    1 = only requester 0 is eligible
//   i_starve_hit   starvation counter has reached its limit
//   o_win_c        one-hot winner (zero when nothing is eligible)
//   o_valid_c      some requester is eligible
//   o_cpu_elig_c   CPU requester is eligible this cycle
module ram_arb_prio
  import ram_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_boot_lock,
  input  logic            i_starve_hit,
  output logic [NREQ-1:0] o_win_c,
  output logic            o_valid_c,
  output logic            o_cpu_elig_c
);

  logic [NREQ-1:0] w_elig;

  always_comb begin
    w_elig = i_req;
    if (i_boot_lock) w_elig = NREQ'(i_req[REQ_BOOT]);

    o_win_c = '0;
    if (i_starve_hit && w_elig[REQ_CPU]) o_win_c[REQ_CPU]  = 1'b1;
    else if (w_elig[REQ_BOOT])           o_win_c[REQ_BOOT] = 1'b1;
    else if (w_elig[REQ_DBG])            o_win_c[REQ_DBG]  = 1'b1;
    else if (w_elig[REQ_CPU])            o_win_c[REQ_CPU]  = 1'b1;

    o_valid_c    = |w_elig;
    o_cpu_elig_c = w_elig[REQ_CPU];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Registered request/grant scheduler sharing one single-port RAM between
// boot loader (0), debug port (1) and CPU (2).
//   clk, rst_n   clock, asynchronous active-low reset
//   ce           clock enable; all state holds while low
//   boot_lock    restricts arbitration to requester 0
//   bus          ram_port_arbiter_if.slave (requests, grants, read data, RAM side)
// Optional: RAM_ARB_STATS_EN adds stats_clr input and acc_cnt output
// (per-requester 16-bit saturating grant counters).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 boot_lock,
  ram_port_arbiter_if.slave    bus
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NREQ*16-1:0]   acc_cnt
`endif
);

  arb_state_e          r_state, w_state_nxt;
  logic [NREQ-1:0]     r_win, w_win;
  logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]     r_rvalid, w_rvalid_nxt;
  logic                r_ram_en, w_ram_en_nxt;
  logic                r_ram_rw, w_ram_rw_nxt;
  logic [ADDR_W-1:0]   r_ram_adr, w_ram_adr_nxt, w_sel_adr;
  logic [DATA_W-1:0]   r_ram_in, w_ram_in_nxt, w_sel_wdata;
  logic                w_sel_we;
  logic                w_valid, w_cpu_elig, w_starve_hit, w_arb;
  logic [STARVE_W-1:0] r_starve;

  assign w_starve_hit = (r_starve == STARVE_W'(STARVE_LIMIT));
  assign w_arb        = (r_state == ST_IDLE) && w_valid;

  ram_arb_prio u_prio (
    .i_req        (bus.req),
    .i_boot_lock  (boot_lock),
    .i_starve_hit (w_starve_hit),
    .o_win_c      (w_win),
    .o_valid_c    (w_valid),
    .o_cpu_elig_c (w_cpu_elig)
  );

  // Route the winning requester's transfer fields
  always_comb begin
    w_sel_we    = bus.we[REQ_BOOT];
    w_sel_adr   = bus.adr[REQ_BOOT*ADDR_W +: ADDR_W];
    w_sel_wdata = bus.wdata[REQ_BOOT*DATA_W +: DATA_W];
    if (w_win[REQ_DBG]) begin
      w_sel_we    = bus.we[REQ_DBG];
      w_sel_adr   = bus.adr[REQ_DBG*ADDR_W +: ADDR_W];
      w_sel_wdata = bus.wdata[REQ_DBG*DATA_W +: DATA_W];
    end else if (w_win[REQ_CPU]) begin
      w_sel_we    = bus.we[REQ_CPU];
      w_sel_adr   = bus.adr[REQ_CPU*ADDR_W +: ADDR_W];
      w_sel_wdata = bus.wdata[REQ_CPU*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_state <= ST_IDLE;
    else if (ce) r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = (r_ram_rw == RAM_WRITE) ? ST_IDLE : ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the state
  // being entered. ACCESS is only entered from IDLE, so the selection mux
  // still holds the winner's fields at that edge.
  always_comb begin
    w_gnt_nxt     = '0;
    w_rvalid_nxt  = '0;
    w_ram_en_nxt  = 1'b0;
    w_ram_rw_nxt  = RAM_READ;
    w_ram_adr_nxt = r_ram_adr;
    w_ram_in_nxt  = r_ram_in;
    case (w_state_nxt)
      ST_ACCESS: begin
        w_gnt_nxt     = w_win;
        w_ram_en_nxt  = 1'b1;
        w_ram_rw_nxt  = w_sel_we;
        w_ram_adr_nxt = w_sel_adr;
        w_ram_in_nxt  = w_sel_wdata;
      end
      ST_RESP: w_rvalid_nxt = r_win;
      default: ;
    endcase
  end

  // Registered outputs and latched winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win     <= '0;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_ram_en  <= 1'b0;
      r_ram_rw  <= RAM_READ;
      r_ram_adr <= '0;
      r_ram_in  <= '0;
    end else if (ce) begin
      if (w_arb) r_win <= w_win;
      r_gnt     <= w_gnt_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_ram_en  <= w_ram_en_nxt;
      r_ram_rw  <= w_ram_rw_nxt;
      r_ram_adr <= w_ram_adr_nxt;
      r_ram_in  <= w_ram_in_nxt;
    end
  end

  // CPU starvation counter, updated only on arbitration cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (ce && w_arb) begin
      if (w_win[REQ_CPU] || !bus.req[REQ_CPU])
        r_starve <= '0;
      else if (w_cpu_elig && !w_starve_hit)
        r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.rvalid     = r_rvalid;
  assign bus.ram_enable = r_ram_en;
  assign bus.ram_rw     = r_ram_rw;
  assign bus.ram_adr    = r_ram_adr;
  assign bus.ram_in     = r_ram_in;
  // RAM output is already registered; forward it only during RESP
  assign bus.rdata      = (r_state == ST_RESP) ? bus.ram_out : '0;

`ifdef RAM_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_acc;

  // Per-requester grant counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (ce) begin
      if (stats_clr) begin
        r_acc <= '0;
      end else begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (w_arb && w_win[i] && (r_acc[i] != 16'hFFFF))
            r_acc[i] <= r_acc[i] + 16'd1;
        end
      end
    end
  end

  assign acc_cnt = r_acc;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural
// 64x16 synchronous RAM.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic ce        = 1'b1;
  logic boot_lock = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef RAM_ARB_STATS_EN
  logic               stats_clr = 1'b0;
  logic [NREQ*16-1:0] acc_cnt;
`endif

  ram_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .boot_lock (boot_lock),
    .bus       (bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .acc_cnt   (acc_cnt)
`endif
  );

  // RAM model with a bench-side preload port
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] ram_q;
  logic              pre_we  = 1'b0;
  logic [ADDR_W-1:0] pre_adr = '0;
  logic [DATA_W-1:0] pre_dat = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_adr] <= pre_dat;
    else if (bus.ram_enable) begin
      if (bus.ram_rw) mem[bus.ram_adr] <= bus.ram_in;
      else            ram_q <= mem[bus.ram_adr];
    end
  end
  assign bus.ram_out = ram_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we  = 1'b1;
    pre_adr = a;
    pre_dat = d;
    tick();
    pre_we  = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req[idx]                    = 1'b1;
    bus.we[idx]                     = w;
    bus.adr[idx*ADDR_W +: ADDR_W]   = a;
    bus.wdata[idx*DATA_W +: DATA_W] = d;
  endtask

  logic [NREQ-1:0] gseq [3];
  int              gcyc [3];
  int              ng;
  int              run;
  int              nruns;
  int              runs [2];
  logic [31:0]     exp_rd;

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.adr   = '0;
    bus.wdata = '0;

    // Preload while reset is held
    preload(6'h05, 16'hBEEF);
    preload(6'h10, 16'hAAAA);
    preload(6'h11, 16'hBBBB);
    preload(6'h12, 16'hCCCC);

    chk("rst_gnt",    32'(bus.gnt),        32'h0);
    chk("rst_rvalid", 32'(bus.rvalid),     32'h0);
    chk("rst_en",     32'(bus.ram_enable), 32'h0);
    chk("rst_rw",     32'(bus.ram_rw),     32'h0);
    chk("rst_adr",    32'(bus.ram_adr),    32'h0);
    chk("rst_in",     32'(bus.ram_in),     32'h0);
    chk("rst_rdata",  32'(bus.rdata),      32'h0);
    rst_n = 1'b1;
    tick();

    // Single CPU read
    set_req(2, 1'b0, 6'h05, 16'h0);
    tick();
    chk("cpu_gnt", 32'(bus.gnt),        32'b100);
    chk("cpu_en",  32'(bus.ram_enable), 32'h1);
    chk("cpu_rw",  32'(bus.ram_rw),     32'h0);
    chk("cpu_adr", 32'(bus.ram_adr),    32'h05);
    bus.req = '0;
    tick();
    chk("cpu_rvalid",  32'(bus.rvalid),     32'b100);
    chk("cpu_rdata",   32'(bus.rdata),      32'hBEEF);
    chk("cpu_gnt_off", 32'(bus.gnt),        32'h0);
    chk("cpu_en_off",  32'(bus.ram_enable), 32'h0);
    tick();
    chk("cpu_rv_off",  32'(bus.rvalid),     32'h0);

    // Three simultaneous reads: order 0,1,2 at 3-cycle spacing
    set_req(0, 1'b0, 6'h10, 16'h0);
    set_req(1, 1'b0, 6'h11, 16'h0);
    set_req(2, 1'b0, 6'h12, 16'h0);
    ng = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.gnt != '0) begin
        chk("all_onehot", 32'($countones(bus.gnt)), 32'd1);
        if (ng < 3) begin
          gseq[ng] = bus.gnt;
          gcyc[ng] = c;
        end
        ng++;
        bus.req = bus.req & ~bus.gnt;
      end
      if (bus.rvalid != '0) begin
        exp_rd = (bus.rvalid == 3'b001) ? 32'hAAAA :
                 (bus.rvalid == 3'b010) ? 32'hBBBB : 32'hCCCC;
        chk("all_rdata", 32'(bus.rdata), exp_rd);
      end
    end
    chk("all_ngnt", 32'(ng), 32'd3);
    chk("all_g0",   32'(gseq[0]), 32'b001);
    chk("all_g1",   32'(gseq[1]), 32'b010);
    chk("all_g2",   32'(gseq[2]), 32'b100);
    chk("all_c0",   32'(gcyc[0]), 32'd1);
    chk("all_c1",   32'(gcyc[1]), 32'd4);
    chk("all_c2",   32'(gcyc[2]), 32'd7);

    // boot_lock blocks requesters 1 and 2
    boot_lock = 1'b1;
    set_req(1, 1'b0, 6'h11, 16'h0);
    set_req(2, 1'b0, 6'h12, 16'h0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("lock_gnt", 32'(bus.gnt),        32'h0);
      chk("lock_en",  32'(bus.ram_enable), 32'h0);
    end
    set_req(0, 1'b1, 6'h3F, 16'h1234);
    tick();
    chk("lock_wgnt", 32'(bus.gnt),    32'b001);
    chk("lock_wrw",  32'(bus.ram_rw), 32'h1);
    chk("lock_wadr", 32'(bus.ram_adr), 32'h3F);
    chk("lock_win",  32'(bus.ram_in), 32'h1234);
    bus.req = '0;
    tick();
    boot_lock = 1'b0;
    set_req(1, 1'b0, 6'h3F, 16'h0);
    tick();
    chk("rb_gnt", 32'(bus.gnt), 32'b010);
    bus.req = '0;
    tick();
    chk("rb_rvalid", 32'(bus.rvalid), 32'b010);
    chk("rb_rdata",  32'(bus.rdata),  32'h1234);
    tick();

    // Starvation: 0 and 2 request continuously, limit 8
    set_req(0, 1'b1, 6'h20, 16'h0101);
    set_req(2, 1'b1, 6'h21, 16'h0202);
    run = 0;
    nruns = 0;
    for (int c = 0; c < 60 && nruns < 2; c++) begin
      tick();
      if (bus.gnt != '0) begin
        chk("stv_onehot", 32'($countones(bus.gnt)), 32'd1);
        if (bus.gnt[0]) run++;
        if (bus.gnt[2]) begin
          runs[nruns] = run;
          nruns++;
          run = 0;
        end
      end
    end
    bus.req = '0;
    chk("stv_nruns", 32'(nruns), 32'd2);
    chk("stv_run1",  32'(runs[0]), 32'd8);
    chk("stv_run2",  32'(runs[1]), 32'd8);
    tick();
    tick();

    // ce low for 5 cycles during RESP
    set_req(2, 1'b0, 6'h05, 16'h0);
    tick();
    chk("ce_gnt", 32'(bus.gnt), 32'b100);
    bus.req = '0;
    tick();
    chk("ce_rv0", 32'(bus.rvalid), 32'b100);
    ce = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ce_hold_rv",  32'(bus.rvalid), 32'b100);
      chk("ce_hold_rd",  32'(bus.rdata),  32'hBEEF);
      chk("ce_hold_gnt", 32'(bus.gnt),    32'h0);
    end
    ce = 1'b1;
    tick();
    chk("ce_rv_done", 32'(bus.rvalid),     32'h0);
    chk("ce_en_done", 32'(bus.ram_enable), 32'h0);
    set_req(0, 1'b0, 6'h10, 16'h0);
    tick();
    chk("ce_next_gnt", 32'(bus.gnt), 32'b001);
    bus.req = '0;
    tick();
    chk("ce_next_rd", 32'(bus.rdata), 32'hAAAA);
    tick();

    // Reset in the middle of requester 1's write
    set_req(1, 1'b1, 6'h0A, 16'h5555);
    tick();
    chk("mr_gnt", 32'(bus.gnt),    32'b010);
    chk("mr_rw",  32'(bus.ram_rw), 32'h1);
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("mr_rst_gnt", 32'(bus.gnt),        32'h0);
    chk("mr_rst_en",  32'(bus.ram_enable), 32'h0);
    chk("mr_rst_rw",  32'(bus.ram_rw),     32'h0);
    chk("mr_rst_adr", 32'(bus.ram_adr),    32'h0);
    chk("mr_rst_in",  32'(bus.ram_in),     32'h0);
    chk("mr_rst_rv",  32'(bus.rvalid),     32'h0);
    chk("mr_rst_rd",  32'(bus.rdata),      32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mr_idle_gnt", 32'(bus.gnt),        32'h0);
    chk("mr_idle_en",  32'(bus.ram_enable), 32'h0);
    set_req(2, 1'b0, 6'h05, 16'h0);
    tick();
    chk("mr_rd_gnt", 32'(bus.gnt), 32'b100);
    bus.req = '0;
    tick();
    chk("mr_rd_rv", 32'(bus.rvalid), 32'b100);
    chk("mr_rd_rd", 32'(bus.rdata),  32'hBEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
